// File: rtl/key_switch_mmio_pkg.sv
// kswmmio_pkg: register offsets and key count shared by the key/switch MMIO block.
package kswmmio_pkg;
    localparam int NUM_KEYS = 4;
    localparam logic [31:0] OFS_SW       = 32'h00;
    localparam logic [31:0] OFS_KEY      = 32'h04;
    localparam logic [31:0] OFS_EDGE     = 32'h08;
    localparam logic [31:0] OFS_COUNT    = 32'h0C;
    localparam logic [31:0] OFS_MASK     = 32'h10;
    localparam logic [31:0] WINDOW_BYTES = 32'h14;
endpackage

// File: rtl/key_switch_mmio_debounce.sv
// key_debounce: synchronizes and debounces one active-low key, emits a one-cycle press pulse.
// Ports: clk, reset_n (async active-low), key_n_i (raw key, active-low),
//        stable_o (debounced level, 1 = pressed), press_o (high in the cycle before stable_o rises).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic stable_o,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d, key_sync, differ, done;
    assign key_sync = ~sync_q[1];
    assign differ   = key_sync != stable_q;
    // Accept the new level on the edge where the counter already sits at its last value.
    assign done     = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    always_comb begin
        cnt_d    = (!differ || done) ? '0 : cnt_q + 1'b1;
        stable_d = done ? key_sync : stable_q;
    end
    // Synchronizer resets to the released level so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_n_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
    assign stable_o = stable_q;
    assign press_o  = done && key_sync;
endmodule

// File: rtl/key_switch_mmio.sv
// key_switch_mmio: memory-mapped key/switch input peripheral with press latching, counters and irq.
// Ports: clk, reset_n (async active-low), key_n (raw keys, active-low), sw (raw switches),
//        addr/wdata/we (CPU data bus), sel (address in window), rdata (combinational read), irq.
module key_switch_mmio
    import kswmmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int          DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  key_n,
    input  logic [9:0]  sw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        irq
);
    logic [9:0]                sw_s1_q, sw_sync_q;
    logic [NUM_KEYS-1:0]       key_stable, press, edge_q, edge_d, mask_q, mask_d;
    logic [NUM_KEYS-1:0][7:0]  cnt_q, cnt_d;
    logic                      irq_q, wr;
    logic [31:0]               addr_w, off;
    logic                      unused;
    assign unused = ^{wdata[31:NUM_KEYS], addr[1:0]};
    assign addr_w = {addr[31:2], 2'b00};
    assign off    = addr_w - BASE_ADDR;
    assign sel    = addr_w >= BASE_ADDR && off < WINDOW_BYTES;
    assign wr     = sel && we;
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .key_n_i  (key_n[i]),
            .stable_o (key_stable[i]),
            .press_o  (press[i])
        );
    end
    // A press in the same cycle as a clearing store wins: set is ORed after the clear.
    always_comb begin
        edge_d = (edge_q & ~((wr && off == OFS_EDGE) ? wdata[NUM_KEYS-1:0] : '0)) | press;
        mask_d = (wr && off == OFS_MASK) ? wdata[NUM_KEYS-1:0] : mask_q;
        for (int i = 0; i < NUM_KEYS; i++)
            cnt_d[i] = ((wr && off == OFS_COUNT) ? 8'd0 : cnt_q[i]) + {7'd0, press[i]};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1_q   <= '0;
            sw_sync_q <= '0;
            edge_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            sw_s1_q   <= sw;
            sw_sync_q <= sw_s1_q;
            edge_q    <= edge_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            irq_q     <= |(edge_q & mask_q);
        end
    end
    assign irq   = irq_q;
    assign rdata = !sel                ? 32'h0 :
                   off == OFS_SW       ? 32'(sw_sync_q) :
                   off == OFS_KEY      ? 32'(key_stable) :
                   off == OFS_EDGE     ? 32'(edge_q) :
                   off == OFS_COUNT    ? cnt_q :
                   off == OFS_MASK     ? 32'(mask_q) : 32'h0;
endmodule

// File: tb/tb_key_switch_mmio.sv
// tb_key_switch_mmio: directed self-checking bench for key_switch_mmio with DEBOUNCE_CYCLES=4.
module tb_key_switch_mmio;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_SW = BASE + 32'h00, A_KEY = BASE + 32'h04, A_EDGE = BASE + 32'h08,
                            A_CNT = BASE + 32'h0C, A_MASK = BASE + 32'h10;
    logic        clk = 1'b0, reset_n = 1'b0, we = 1'b0, sel, irq;
    logic [3:0]  key_n = 4'h0;
    logic [9:0]  sw = '0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    int n_checks = 0, n_fail = 0;

    key_switch_mmio #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .key_n(key_n), .sw(sw), .addr(addr),
        .wdata(wdata), .we(we), .sel(sel), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic press_release(input int k);
        key_n[k] = 1'b0;
        tick(6);
        key_n[k] = 1'b1;
        tick(6);
    endtask

    initial begin
        // Reset with keys held, then release keys before reset ends
        tick(3);
        rd("rst_key", A_KEY, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        key_n = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        rd("post_rst_key", A_KEY, 32'h0);
        rd("post_rst_edge", A_EDGE, 32'h0);
        rd("post_rst_cnt", A_CNT, 32'h0);
        chk("post_rst_irq", 32'(irq), 32'h0);

        // Clean press on key 1 with mask bit 1 enabled
        wr(A_MASK, 32'h2);
        rd("mask_rd", A_MASK, 32'h2);
        key_n[1] = 1'b0;
        tick(5);
        rd("press_key_e5", A_KEY, 32'h0);
        rd("press_edge_e5", A_EDGE, 32'h0);
        tick(1);
        rd("press_key_e6", A_KEY, 32'h2);
        rd("press_edge_e6", A_EDGE, 32'h2);
        rd("press_cnt", A_CNT, 32'h0000_0100);
        chk("press_irq_e6", 32'(irq), 32'h0);
        tick(1);
        chk("press_irq_e7", 32'(irq), 32'h1);
        key_n[1] = 1'b1;
        tick(8);
        rd("release_key", A_KEY, 32'h0);
        rd("release_cnt", A_CNT, 32'h0000_0100);
        wr(A_EDGE, 32'h2);
        rd("w1c_edge", A_EDGE, 32'h0);
        tick(1);
        chk("w1c_irq", 32'(irq), 32'h0);
        wr(A_CNT, 32'h0);
        rd("cnt_clr", A_CNT, 32'h0);

        // Bounce rejection on key 0
        repeat (5) begin
            key_n[0] = 1'b0;
            tick(3);
            key_n[0] = 1'b1;
            tick(3);
        end
        tick(8);
        rd("bounce_key", A_KEY, 32'h0);
        rd("bounce_edge", A_EDGE, 32'h0);
        rd("bounce_cnt", A_CNT, 32'h0);

        // W1C colliding with a press on key 0
        press_release(0);
        rd("pre_coll_edge", A_EDGE, 32'h1);
        key_n[0] = 1'b0;
        tick(5);
        wr(A_EDGE, 32'h1);
        rd("coll_edge", A_EDGE, 32'h1);
        rd("coll_cnt", A_CNT, 32'h0000_0002);
        key_n[0] = 1'b1;
        tick(8);

        // COUNT write colliding with a press on key 0
        key_n[0] = 1'b0;
        tick(5);
        wr(A_CNT, 32'hFFFF_FFFF);
        rd("cnt_coll", A_CNT, 32'h0000_0001);
        key_n[0] = 1'b1;
        tick(8);

        // Counter wrap on key 3
        wr(A_EDGE, 32'hF);
        wr(A_CNT, 32'h0);
        rd("wrap_pre_edge", A_EDGE, 32'h0);
        for (int i = 0; i < 255; i++) press_release(3);
        rd("wrap_255", A_CNT, 32'hFF00_0000);
        press_release(3);
        rd("wrap_256", A_CNT, 32'h0);
        rd("wrap_edge", A_EDGE, 32'h8);
        chk("wrap_irq_masked", 32'(irq), 32'h0);
        press_release(3);
        rd("wrap_257", A_CNT, 32'h0100_0000);
        wr(A_CNT, 32'h1234);
        rd("cnt_any_clr", A_CNT, 32'h0);
        wr(A_MASK, 32'hFFFF_FFF8);
        rd("mask_upper_ign", A_MASK, 32'h8);
        tick(1);
        chk("irq_mask3", 32'(irq), 32'h1);

        // Switches and decode
        sw = 10'h2A5;
        tick(1);
        rd("sw_e1", A_SW, 32'h0);
        tick(1);
        rd("sw_e2", A_SW, 32'h0000_02A5);
        rd("out_hi_rdata", BASE + 32'h14, 32'h0);
        chk("out_hi_sel", 32'(sel), 32'h0);
        rd("out_lo_rdata", BASE - 32'h4, 32'h0);
        chk("out_lo_sel", 32'(sel), 32'h0);
        rd("byte_ofs_mask", BASE + 32'h13, 32'h8);
        chk("in_sel", 32'(sel), 32'h1);
        wr(A_KEY, 32'hFFFF_FFFF);
        rd("ro_key", A_KEY, 32'h0);
        wr(A_SW, 32'h0);
        rd("ro_sw", A_SW, 32'h0000_02A5);
        wr(BASE + 32'h14, 32'h0);
        rd("out_wr_mask", A_MASK, 32'h8);

        // Reset mid-debounce
        key_n[2] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        #1;
        rd("mid_rst_key", A_KEY, 32'h0);
        rd("mid_rst_edge", A_EDGE, 32'h0);
        rd("mid_rst_mask", A_MASK, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        key_n = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        rd("after_rst_edge", A_EDGE, 32'h0);
        rd("after_rst_cnt", A_CNT, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
